// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 state encoding, error codes and cycle-count helper shared by host transmitter and receiver
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE,
        ST_ERR
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_FRAME = 2'b10;
    localparam logic [1:0] ERR_NOACK = 2'b11;

    // 64-bit product: CLK_HZ * START_TO_US overflows 32 bits at the default settings
    function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
        longint unsigned p;
        p = 64'(clk_hz) * 64'(us) / 64'd1_000_000;
        return p[31:0];
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronizes one PS/2 pin, rejects glitches shorter than FILT cycles, flags falling edges
module ps2_line_filter #(
    parameter int unsigned FILT = 8
) (
    input  logic clk50,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILT + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          prev;

    // level follows the synchronized pin only after FILT consecutive differing cycles
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync <= {sync[0], pin};
            prev <= level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign fall = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one host-to-device PS/2 byte over open-drain clk/data and reports the device ACK
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned INHIBIT_US  = 120,
    parameter int unsigned START_TO_US = 15000,
    parameter int unsigned FRAME_TO_US = 2000,
    parameter int unsigned FILT        = 8
) (
    input  logic       clk50,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    output logic       busy,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned INHIB_C = us_to_cycles(CLK_HZ, INHIBIT_US);
    localparam int unsigned START_C = us_to_cycles(CLK_HZ, START_TO_US);
    localparam int unsigned FRAME_C = us_to_cycles(CLK_HZ, FRAME_TO_US);
    localparam int unsigned MAX_AB  = (INHIB_C > START_C) ? INHIB_C : START_C;
    localparam int unsigned MAX_C   = (MAX_AB > FRAME_C) ? MAX_AB : FRAME_C;
    localparam int          CW      = $clog2(MAX_C + 1);

    ps2_state_t    state, state_d;
    logic [CW-1:0] cnt, cnt_d, cnt_inc;
    logic [9:0]    sh, sh_d;
    logic [3:0]    n, n_d;
    logic [1:0]    err_d;
    logic          clk_lvl, clk_fall, dat_lvl, dat_fall_unused;

    ps2_line_filter #(.FILT(FILT)) u_clk_filt (
        .clk50 (clk50),
        .rst_n (rst_n),
        .pin   (ps2_clk_i),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILT(FILT)) u_dat_filt (
        .clk50 (clk50),
        .rst_n (rst_n),
        .pin   (ps2_dat_i),
        .level (dat_lvl),
        .fall  (dat_fall_unused)
    );

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sh       <= '1;
            n        <= '0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            sh       <= sh_d;
            n        <= n_d;
            err_code <= err_d;
        end
    end

    // one timer serves inhibit, start timeout and (from the first device fall) the frame timeout
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sh_d    = sh;
        n_d     = n;
        err_d   = err_code;
        cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
        unique case (state)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_d = ST_INHIBIT;
                    cnt_d   = '0;
                    sh_d    = {1'b1, ~^tx_data, tx_data};
                    n_d     = '0;
                    err_d   = ERR_NONE;
                end
            end
            ST_INHIBIT: begin
                cnt_d = cnt_inc;
                if (cnt == CW'(INHIB_C - 1)) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc;
                if (clk_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    n_d     = 4'd1;
                end else if (cnt == CW'(START_C - 1)) begin
                    state_d = ST_ERR;
                    err_d   = ERR_START;
                end
            end
            ST_SHIFT, ST_ACK, ST_WAIT_IDLE: begin
                cnt_d = cnt_inc;
                if (cnt == CW'(FRAME_C - 1)) begin
                    state_d = ST_ERR;
                    err_d   = ERR_FRAME;
                end else if (state == ST_SHIFT && clk_fall) begin
                    sh_d    = {1'b1, sh[9:1]};
                    n_d     = n + 4'd1;
                    state_d = (n == 4'd9) ? ST_ACK : ST_SHIFT;
                end else if (state == ST_ACK && clk_fall) begin
                    state_d = dat_lvl ? ST_ERR : ST_WAIT_IDLE;
                    err_d   = dat_lvl ? ERR_NOACK : err_code;
                end else if (state == ST_WAIT_IDLE && clk_lvl && dat_lvl) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tx_ready   = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign tx_done    = (state == ST_DONE);
    assign tx_err     = (state == ST_ERR);
    assign ps2_clk_oe = (state == ST_INHIBIT);
    assign ps2_dat_oe = (state == ST_REQ) || (state == ST_SHIFT && !sh[0]) ||
                        (state == ST_INHIBIT && cnt == CW'(INHIB_C - 1));

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 keyboard and checks frames, ACK and timeouts
module tb_ps2_host_tx;

    localparam int unsigned CLK_HZ      = 1_000_000;
    localparam int unsigned INHIBIT_US  = 120;
    localparam int unsigned START_TO_US = 15000;
    localparam int unsigned FRAME_TO_US = 2000;
    localparam int unsigned FILT        = 8;
    // 1 MHz system clock: one cycle per microsecond
    localparam int INHIB = 120;
    localparam int START = 15000;
    localparam int FRAME = 2000;
    localparam int HALF  = 40;

    logic       clk50 = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_dat_oe;
    logic [1:0] err_code;
    logic       ps2_clk_i, ps2_dat_i;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   end_cyc = 0;
    logic [1:0] end_code = 2'b00;
    logic end_oe = 1'b0;

    assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .CLK_HZ      (CLK_HZ),
        .INHIBIT_US  (INHIBIT_US),
        .START_TO_US (START_TO_US),
        .FRAME_TO_US (FRAME_TO_US),
        .FILT        (FILT)
    ) dut (
        .clk50      (clk50),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .err_code   (err_code),
        .busy       (busy),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 clk50 = ~clk50;

    always @(posedge clk50) cyc++;

    always @(negedge clk50) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done || tx_err) begin
            end_cyc  = cyc;
            end_code = err_code;
            end_oe   = ps2_clk_oe | ps2_dat_oe;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // wire image of the frame: data LSB first, odd parity, stop = 1
    function automatic logic [9:0] model(input logic [7:0] b);
        int v;
        v = int'(b) + 512;
        if ($countones(b) % 2 == 0) v += 256;
        return 10'(v);
    endfunction

    task automatic start_tx(input logic [7:0] b, input bit poke, output int t0);
        int n;
        logic last;
        n = 0;
        last = 1'b0;
        while (!tx_ready && n < 200) begin
            @(negedge clk50);
            n++;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk50);
        tx_valid = 1'b0;
        chk("busy_on_accept", busy, 1);
        chk("ready_low", tx_ready, 0);
        n = 0;
        while (ps2_clk_oe && n < INHIB + 50) begin
            last     = ps2_dat_oe;
            tx_valid = poke && n < 5;
            tx_data  = ~b;
            n++;
            @(negedge clk50);
        end
        tx_valid = 1'b0;
        chk("inhibit_len", n, INHIB);
        chk("start_bit_drive", last, 1);
        t0 = cyc;
    endtask

    // keyboard: clocks at 12.5 kHz, samples data late in each low phase, optional ACK and clock glitch
    task automatic device(input int edges, input bit ack, input int glitch_at,
                          output logic [9:0] got, output logic sb, output int tf);
        got = '1;
        sb  = 1'b1;
        tf  = 0;
        for (int i = 1; i <= edges; i++) begin
            if (i == 11 && ack) dev_dat_low = 1'b1;
            if (i == glitch_at) begin
                repeat (15) @(negedge clk50);
                dev_clk_low = 1'b1;
                repeat (3) @(negedge clk50);
                dev_clk_low = 1'b0;
                repeat (HALF - 18) @(negedge clk50);
            end else begin
                repeat (HALF) @(negedge clk50);
            end
            if (i == 1) begin
                sb = ps2_dat_i;
                tf = cyc;
            end
            dev_clk_low = 1'b1;
            repeat (HALF - 10) @(negedge clk50);
            if (i <= 10) got[i-1] = ps2_dat_i;
            repeat (10) @(negedge clk50);
            dev_clk_low = 1'b0;
        end
        repeat (10) @(negedge clk50);
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_end(input int bound);
        int k;
        k = 0;
        while (done_cnt + err_cnt == 0 && k < bound) begin
            @(negedge clk50);
            k++;
        end
        chk("end_seen", (done_cnt + err_cnt) != 0, 1);
    endtask

    task automatic xact(input logic [7:0] b, input int edges, input bit ack, input int glitch_at,
                        input bit poke, input logic [1:0] exp_code);
        logic [9:0] got;
        logic sb;
        int t0, tf;
        done_cnt = 0;
        err_cnt  = 0;
        start_tx(b, poke, t0);
        got = '1;
        sb  = 1'b1;
        tf  = t0;
        if (edges > 0) device(edges, ack, glitch_at, got, sb, tf);
        wait_end(edges == 0 ? START + 50 : FRAME + 50);
        chk("err_code", end_code, exp_code);
        chk("lines_at_end", end_oe, 0);
        if (edges == 0) chk("start_timeout_cycles", end_cyc - t0, START);
        if (edges > 0 && edges < 11)
            chk("frame_timeout_window", (end_cyc - tf >= FRAME) && (end_cyc - tf <= FRAME + int'(FILT) + 6), 1);
        if (edges == 11) begin
            chk("start_bit", sb, 0);
            chk("frame_bits", got, model(b));
        end
        repeat (4) @(negedge clk50);
        chk("done_pulses", done_cnt, exp_code == 2'b00);
        chk("err_pulses", err_cnt, exp_code != 2'b00);
        chk("ready_after", tx_ready, 1);
        chk("busy_after", busy, 0);
        chk("code_holds", err_code, exp_code);
        chk("clk_released_after", ps2_clk_oe, 0);
    endtask

    initial begin
        logic [9:0] got;
        logic sb;
        int t0, tf;
        repeat (3) @(negedge clk50);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_err", tx_err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_dat_oe", ps2_dat_oe, 0);
        rst_n = 1'b1;
        @(negedge clk50);

        xact(8'hED, 11, 1'b1, 0, 1'b0, 2'b00);
        xact(8'h02, 11, 1'b1, 0, 1'b1, 2'b00);
        xact(8'hFF, 11, 1'b1, 0, 1'b0, 2'b00);
        for (int r = 0; r < 4; r++) xact(8'($urandom), 11, 1'b1, 0, 1'b0, 2'b00);
        xact(8'h55, 11, 1'b1, 3, 1'b0, 2'b00);
        xact(8'h00, 0, 1'b0, 0, 1'b0, 2'b01);
        xact(8'hA3, 11, 1'b0, 0, 1'b0, 2'b11);
        xact(8'h3C, 5, 1'b1, 0, 1'b0, 2'b10);

        start_tx(8'h00, 1'b0, t0);
        device(4, 1'b0, 0, got, sb, tf);
        chk("shift_drives_zero", ps2_dat_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_clk_oe", ps2_clk_oe, 0);
        chk("midrst_dat_oe", ps2_dat_oe, 0);
        chk("midrst_ready", tx_ready, 1);
        chk("midrst_busy", busy, 0);
        @(negedge clk50);
        rst_n = 1'b1;
        repeat (2) @(negedge clk50);

        xact(8'($urandom), 11, 1'b1, 0, 1'b0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
